// File: rtl/uart_pkg.sv
// Shared UART constants: FSM state encodings and baud divider arithmetic.
// Meant to be reused by a companion transmitter.
package uart_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE  = ST_IDLE,
    S_START = ST_START,
    S_DATA  = ST_DATA,
    S_STOP  = ST_STOP
  } rx_state_t;

  // Clock cycles per bit, truncated.
  function automatic int baud_cnt_max(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

  function automatic int baud_half(input int clk_freq, input int baud);
    return baud_cnt_max(clk_freq, baud) / 2;
  endfunction

endpackage

// File: rtl/uart_rx_byte_if.sv
// Receiver-side bus: serial line in, received byte and status pulses out.
interface uart_rx_byte_if;
  logic       rx;
  logic [7:0] rx_data;
  logic       valid_flag;
  logic       frame_err;

  modport slave  (input rx,  output rx_data, output valid_flag, output frame_err);
  modport master (output rx, input rx_data,  input valid_flag,  input frame_err);
endinterface

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the asynchronous rx pin plus a third flop for
// falling-edge detection. All flops reset to the idle (high) line level.
module uart_rx_sync (
  input  logic sys_clk,
  input  logic rst_n,
  input  logic i_rx,
  output logic o_rx_sync,
  output logic o_start_edge
);

  logic [2:0] r_sync;

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= 3'b111;
    end else begin
      r_sync <= {r_sync[1:0], i_rx};
    end
  end

  assign o_rx_sync    = r_sync[1];
  assign o_start_edge = r_sync[2] & ~r_sync[1];

endmodule

// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver, LSB first, mid-bit sampling. Emits a one-cycle valid
// pulse with the byte, or a one-cycle frame_err pulse when the stop bit is low.
module uart_rx_byte
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 9600
) (
  input  logic           sys_clk,
  input  logic           rst_n,
  uart_rx_byte_if.slave  bus
);

  localparam int BAUD_CNT_MAX = baud_cnt_max(CLK_FREQ, BAUD);
  localparam int HALF         = baud_half(CLK_FREQ, BAUD);
  localparam int CNT_W        = $clog2(BAUD_CNT_MAX);

  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(BAUD_CNT_MAX - 1);
  localparam logic [CNT_W-1:0] CNT_SAMPLE = CNT_W'(HALF);

  generate
    if (BAUD_CNT_MAX < 4) begin : g_bad_baud
      $error("uart_rx_byte: CLK_FREQ/BAUD must be at least 4");
    end
  endgenerate

  logic w_rx_sync;
  logic w_start_edge;

  uart_rx_sync u_sync (
    .sys_clk      (sys_clk),
    .rst_n        (rst_n),
    .i_rx         (bus.rx),
    .o_rx_sync    (w_rx_sync),
    .o_start_edge (w_start_edge)
  );

  rx_state_t        r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_bit_idx;
  logic [7:0]       r_shift;
  logic [7:0]       r_rx_data;
  logic             r_valid;
  logic             r_ferr;

  rx_state_t        w_state_next;
  logic [CNT_W-1:0] w_cnt_next;
  logic [2:0]       w_bit_next;
  logic [7:0]       w_shift_next;
  logic [7:0]       w_data_next;
  logic             w_valid_next;
  logic             w_ferr_next;

  logic w_sample;
  logic w_wrap;

  assign w_sample = (r_cnt == CNT_SAMPLE);
  assign w_wrap   = (r_cnt == CNT_LAST);

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_bit_next   = r_bit_idx;
    w_shift_next = r_shift;
    w_data_next  = r_rx_data;
    w_valid_next = 1'b0;
    w_ferr_next  = 1'b0;

    if (r_state != S_IDLE) begin
      w_cnt_next = w_wrap ? '0 : r_cnt + CNT_W'(1);
    end

    case (r_state)
      S_IDLE: begin
        w_cnt_next = '0;
        w_bit_next = '0;
        if (w_start_edge) begin
          w_state_next = S_START;
        end
      end
      S_START: begin
        // High at mid start bit means a glitch, not a real start.
        if (w_sample && w_rx_sync) begin
          w_state_next = S_IDLE;
          w_cnt_next   = '0;
        end else if (w_wrap) begin
          w_state_next = S_DATA;
        end
      end
      S_DATA: begin
        if (w_sample) begin
          w_shift_next[r_bit_idx] = w_rx_sync;
        end
        if (w_wrap) begin
          if (r_bit_idx == 3'd7) begin
            w_state_next = S_STOP;
            w_bit_next   = '0;
          end else begin
            w_bit_next = r_bit_idx + 3'd1;
          end
        end
      end
      S_STOP: begin
        // Leave at mid stop bit so a following start bit is not missed.
        if (w_sample) begin
          w_state_next = S_IDLE;
          w_cnt_next   = '0;
          if (w_rx_sync) begin
            w_data_next  = r_shift;
            w_valid_next = 1'b1;
          end else begin
            w_ferr_next = 1'b1;
          end
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_rx_data <= '0;
      r_valid   <= 1'b0;
      r_ferr    <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_cnt     <= w_cnt_next;
      r_bit_idx <= w_bit_next;
      r_shift   <= w_shift_next;
      r_rx_data <= w_data_next;
      r_valid   <= w_valid_next;
      r_ferr    <= w_ferr_next;
    end
  end

  assign bus.rx_data    = r_rx_data;
  assign bus.valid_flag = r_valid;
  assign bus.frame_err  = r_ferr;

endmodule

// File: tb/tb_uart_rx_byte.sv
// Directed bench for uart_rx_byte: table of frames plus hand-written
// sequences for back-to-back, glitch, bad stop, mid-frame reset and defaults.
module tb_uart_rx_byte;
  import uart_pkg::*;

  localparam int M   = 16;
  localparam int H   = 8;
  localparam int LAT = 3 + 9 * M + H + 1;
  localparam int M2  = 5208;
  localparam int H2  = 2604;
  localparam int LAT2 = 3 + 9 * M2 + H2 + 1;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  uart_rx_byte_if u_if ();
  uart_rx_byte_if u_if2 ();

  uart_rx_byte #(.CLK_FREQ(16), .BAUD(1)) dut (
    .sys_clk (clk),
    .rst_n   (rst_n),
    .bus     (u_if)
  );

  uart_rx_byte dut2 (
    .sys_clk (clk),
    .rst_n   (rst_n),
    .bus     (u_if2)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end else begin
      $display("[TB] ok   %s: 0x%0h", name, act);
    end
  endtask

  int vcount = 0, fcount = 0, vcyc = 0, fcyc = 0;
  int vcount2 = 0, vcyc2 = 0;
  logic [7:0] data2 = 8'h00;
  logic [7:0] rx_q[$];

  always @(negedge clk) begin
    if (u_if.valid_flag) begin
      vcount++;
      vcyc = cyc;
      rx_q.push_back(u_if.rx_data);
    end
    if (u_if.frame_err) begin
      fcount++;
      fcyc = cyc;
    end
    if (u_if.valid_flag || u_if.frame_err)
      check("valid/ferr exclusive", int'(u_if.valid_flag & u_if.frame_err), 0);
    if (u_if2.valid_flag) begin
      vcount2++;
      vcyc2 = cyc;
      data2 = u_if2.rx_data;
    end
  end

  // Drives one 10-bit frame starting at the current negedge; ends on a negedge.
  task automatic send_frame(input logic [7:0] d, input logic stop, input bit sel,
                            input int per, output int p);
    logic [9:0] bits;
    bits = {stop, d, 1'b0};
    p = cyc;
    for (int k = 0; k < 10; k++) begin
      if (sel) u_if2.rx = bits[k];
      else     u_if.rx  = bits[k];
      repeat (per) @(negedge clk);
    end
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         exp_v;
    int         exp_f;
    logic [7:0] exp_data;
  } vec_t;

  vec_t vecs[6];

  task automatic run_vec(input vec_t v, input string tag);
    int v0, f0, p;
    v0 = vcount;
    f0 = fcount;
    send_frame(v.data, v.stop, 1'b0, M, p);
    u_if.rx = 1'b1;
    repeat (M) @(negedge clk);
    check({tag, " valid pulses"}, vcount - v0, v.exp_v);
    check({tag, " ferr pulses"}, fcount - f0, v.exp_f);
    check({tag, " rx_data"}, int'(u_if.rx_data), int'(v.exp_data));
    if (v.exp_v != 0) check({tag, " valid latency"}, vcyc - p, LAT);
    else if (v.exp_f != 0) check({tag, " ferr latency"}, fcyc - p, LAT);
  endtask

  initial begin
    int v0, f0, p;
    vec_t hv;

    rst_n    = 1'b0;
    u_if.rx  = 1'b1;
    u_if2.rx = 1'b1;
    repeat (2) @(negedge clk);
    check("reset rx_data", int'(u_if.rx_data), 0);
    check("reset valid", int'(u_if.valid_flag), 0);
    check("reset ferr", int'(u_if.frame_err), 0);
    check("reset rx_data dflt", int'(u_if2.rx_data), 0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    vecs[0] = '{8'hA5, 1'b1, 1, 0, 8'hA5};
    vecs[1] = '{8'h42, 1'b1, 1, 0, 8'h42};
    vecs[2] = '{8'h66, 1'b1, 1, 0, 8'h66};
    vecs[3] = '{8'hFF, 1'b0, 0, 1, 8'h66};
    vecs[4] = '{8'h00, 1'b1, 1, 0, 8'h00};
    vecs[5] = '{8'h3C, 1'b1, 1, 0, 8'h3C};
    for (int i = 0; i < 6; i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
    end

    // Back-to-back frames with no idle gap.
    rx_q.delete();
    send_frame(8'h42, 1'b1, 1'b0, M, p);
    send_frame(8'h66, 1'b1, 1'b0, M, p);
    u_if.rx = 1'b1;
    repeat (M) @(negedge clk);
    check("b2b count", rx_q.size(), 2);
    if (rx_q.size() == 2) begin
      check("b2b byte0", int'(rx_q[0]), 8'h42);
      check("b2b byte1", int'(rx_q[1]), 8'h66);
    end

    // Short low glitch must not produce a frame.
    v0 = vcount;
    f0 = fcount;
    u_if.rx = 1'b0;
    repeat (4) @(negedge clk);
    u_if.rx = 1'b1;
    repeat (2 * M) @(negedge clk);
    check("glitch valid", vcount - v0, 0);
    check("glitch ferr", fcount - f0, 0);
    check("glitch idle", int'(dut.r_state), int'(ST_IDLE));
    hv = '{8'h3C, 1'b1, 1, 0, 8'h3C};
    run_vec(hv, "post-glitch");

    // Bad stop bit, then line held low: no retrigger.
    v0 = vcount;
    f0 = fcount;
    send_frame(8'hFF, 1'b0, 1'b0, M, p);
    repeat (3 * M) @(negedge clk);
    check("badstop ferr", fcount - f0, 1);
    check("badstop valid", vcount - v0, 0);
    check("badstop rx_data", int'(u_if.rx_data), 8'h3C);
    check("held-low idle", int'(dut.r_state), int'(ST_IDLE));
    u_if.rx = 1'b1;
    repeat (M) @(negedge clk);
    hv = '{8'h81, 1'b1, 1, 0, 8'h81};
    run_vec(hv, "after-hold");

    // Reset during data bit 4.
    v0 = vcount;
    f0 = fcount;
    for (int k = 0; k < 5; k++) begin
      u_if.rx = (k == 0) ? 1'b0 : ~u_if.rx;
      repeat (M) @(negedge clk);
    end
    u_if.rx = 1'b1;
    repeat (M / 2) @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("midrst rx_data", int'(u_if.rx_data), 0);
    check("midrst valid", int'(u_if.valid_flag), 0);
    check("midrst ferr", int'(u_if.frame_err), 0);
    rst_n = 1'b1;
    repeat (2 * M) @(negedge clk);
    check("midrst no valid", vcount - v0, 0);
    check("midrst no ferr", fcount - f0, 0);
    hv = '{8'h5A, 1'b1, 1, 0, 8'h5A};
    run_vec(hv, "post-reset");

    // Default parameters: 5208 cycles per bit.
    send_frame(8'h62, 1'b1, 1'b1, M2, p);
    u_if2.rx = 1'b1;
    repeat (100) @(negedge clk);
    check("dflt valid count", vcount2, 1);
    check("dflt rx_data", int'(data2), 8'h62);
    check("dflt latency", vcyc2 - p, LAT2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
